// File: rtl/keypad_pkg.sv
// Shared state encoding, hex key map and column decode for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] index;
    } col_hit_t;

    // Indexed [row][col]; the bottom row is not in numeric order on the keypad.
    localparam logic [0:3][0:3][3:0] KEY_MAP = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic col_hit_t onehot_low_index(input logic [3:0] v);
        col_hit_t hit;
        hit = '0;
        case (v)
            4'b1110: hit = '{valid: 1'b1, index: 2'd0};
            4'b1101: hit = '{valid: 1'b1, index: 2'd1};
            4'b1011: hit = '{valid: 1'b1, index: 2'd2};
            4'b0111: hit = '{valid: 1'b1, index: 2'd3};
            default: hit = '0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the active-low keypad columns; idles at all-released.
module keypad_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_fsm.sv
// 4x4 keypad scanner: row sequencing, press/release debounce, one event per press, 2-digit history.
// Define KEYPAD_REPEAT_EN to emit repeat events every REPEAT_CYCLES while a key stays held.
module keypad_scan_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_CYCLES   = 12000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] digits
);

    localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    if (SCAN_CYCLES < 3 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
        $error("keypad_scan_fsm: parameter below its minimum");
    end

    state_t           state, state_d;
    logic [1:0]       row, row_d;
    logic [1:0]       col, col_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       scols;
    logic [3:0]       rows_d;
    logic             key_valid_d;
    logic [3:0]       key_code_d;
    logic [7:0]       digits_d;
    logic             fire_c;
    logic             match_c;
    logic             key_up_c;
    logic [3:0]       key_sel_c;
    col_hit_t         hit_c;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES);
    logic [REP_W-1:0] rep_cnt, rep_cnt_d;
`endif

    keypad_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cols),
        .q     (scols)
    );

    assign hit_c     = onehot_low_index(scols);
    assign match_c   = (scols == ~(4'b0001 << col));
    assign key_up_c  = scols[col];
    assign key_sel_c = KEY_MAP[row][col];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            row       <= '0;
            col       <= '0;
            cnt       <= '0;
            rows      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= '0;
            digits    <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            state     <= state_d;
            row       <= row_d;
            col       <= col_d;
            cnt       <= cnt_d;
            rows      <= rows_d;
            key_valid <= key_valid_d;
            key_code  <= key_code_d;
            digits    <= digits_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt   <= rep_cnt_d;
`endif
        end
    end

    // Next-state logic; fire_c marks the cycle whose edge publishes a key event.
    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        cnt_d   = cnt;
        fire_c  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d = '0;
`endif
        case (state)
            SCAN: begin
                if (cnt == CNT_W'(SCAN_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (hit_c.valid) begin
                        col_d   = hit_c.index;
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row + 2'd1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!match_c) begin
                    state_d = SCAN;
                    row_d   = row + 2'd1;
                    cnt_d   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    fire_c  = 1'b1;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (key_up_c) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
                    fire_c = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt + REP_W'(1);
                end
`endif
            end
            RELEASE: begin
                if (!key_up_c) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = SCAN;
                    row_d   = row + 2'd1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
                row_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values registered alongside the state; rows track the next row index.
    always_comb begin
        rows_d      = ~(4'b0001 << row_d);
        key_valid_d = fire_c;
        key_code_d  = key_code;
        digits_d    = digits;
        if (fire_c) begin
            key_code_d = key_sel_c;
            digits_d   = {digits[3:0], key_sel_c};
        end
    end

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Self-checking bench for keypad_scan_fsm: a modelled key matrix, randomized presses and a
// spec-level expectation of events, codes, digit history and scan timing.
module tb_keypad_scan_fsm;

    localparam int unsigned SCAN_CYCLES     = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 8;
    localparam int unsigned REPEAT_CYCLES   = 32;
    // Release reaches scols after 2 flops, HELD spends one cycle noticing, then the release debounce.
    localparam int RESUME_LATENCY = 3 + int'(DEBOUNCE_CYCLES);

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] digits;

    logic [15:0] pressed = '0;
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [7:0]  model_digits = '0;

    logic [3:0] ev_code[$];
    logic [3:0] ev_rows[$];
    int         ev_cyc[$];

    logic       prev_kv     = 1'b0;
    logic [3:0] prev_code   = '0;
    logic [7:0] prev_digits = '0;

    keypad_scan_fsm #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    // Passive key matrix: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    // Event capture plus the per-cycle pulse and hold rules.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            ev_code.push_back(key_code);
            ev_rows.push_back(rows);
            ev_cyc.push_back(cyc);
        end
        if (reset === 1'b0) begin
            checks++;
            if (key_valid === 1'b1 && prev_kv === 1'b1) begin
                failures++;
                $display("FAIL kv_consecutive cycle=%0d key_valid high twice in a row", cyc);
            end
            checks++;
            if (key_valid !== 1'b1 && (key_code !== prev_code || digits !== prev_digits)) begin
                failures++;
                $display("FAIL outputs_held cycle=%0d code=%h was=%h digits=%h was=%h",
                         cyc, key_code, prev_code, digits, prev_digits);
            end
        end
        prev_kv     = key_valid;
        prev_code   = key_code;
        prev_digits = digits;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] key_of(input int r, input int c);
        logic [63:0] tbl;
        tbl = 64'h123A_456B_789C_E0FD;
        return tbl[63 - 4*(r*4+c) -: 4];
    endfunction

    function automatic logic [3:0] row_drive(input int r);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << r);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_events();
        ev_code.delete();
        ev_rows.delete();
        ev_cyc.delete();
    endtask

    task automatic wait_event(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (ev_code.size() > 0) got = 1'b1;
        end
    endtask

    task automatic press_and_release(input int r, input int c, input int hold);
        bit         got;
        int         lat;
        int         t0;
        logic [3:0] code;
        logic [3:0] held_rows;
        logic [3:0] next_rows;
        code      = key_of(r, c);
        held_rows = row_drive(r);
        next_rows = row_drive((r + 1) % 4);
        clear_events();
        t0 = cyc;
        pressed[r*4+c] = 1'b1;
        wait_event(80, got);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL press_timeout key=%h got no key_valid, required one within 80 cycles", code);
        end
        tick(hold);
        pressed = '0;
        lat = 0;
        while (rows === held_rows && lat < 40) begin
            tick(1);
            lat++;
        end
        checks++;
        if (lat != RESUME_LATENCY) begin
            failures++;
            $display("FAIL resume_latency key=%h got=%0d required=%0d", code, lat, RESUME_LATENCY);
        end
        checks++;
        if (rows !== next_rows) begin
            failures++;
            $display("FAIL resume_row key=%h got=%b required=%b", code, rows, next_rows);
        end
        tick(6);
        model_digits = {model_digits[3:0], code};
        checks++;
        if (ev_code.size() != 1) begin
            failures++;
            $display("FAIL event_count key=%h got=%0d required=1", code, ev_code.size());
        end
        if (ev_code.size() > 0) begin
            checks++;
            if (ev_code[0] !== code) begin
                failures++;
                $display("FAIL event_code got=%h required=%h", ev_code[0], code);
            end
            checks++;
            if (ev_rows[0] !== held_rows) begin
                failures++;
                $display("FAIL event_rows key=%h got=%b required=%b", code, ev_rows[0], held_rows);
            end
            checks++;
            if (ev_cyc[0] - t0 > 40) begin
                failures++;
                $display("FAIL event_latency key=%h got=%0d required<=40", code, ev_cyc[0] - t0);
            end
        end
        checks++;
        if (key_code !== code) begin
            failures++;
            $display("FAIL key_code_hold got=%h required=%h", key_code, code);
        end
        checks++;
        if (digits !== model_digits) begin
            failures++;
            $display("FAIL digits got=%h required=%h", digits, model_digits);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        @(negedge clk);
        reset   = 1'b1;
        pressed = '0;
        tick(2);
        reset = 1'b0;
        model_digits = '0;
        clear_events();
        checks++;
        if (rows !== 4'b1110) begin failures++; $display("FAIL reset_rows got=%b required=1110", rows); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_key_valid got=%b required=0", key_valid); end
        checks++;
        if (key_code !== 4'h0) begin failures++; $display("FAIL reset_key_code got=%h required=0", key_code); end
        checks++;
        if (digits !== 8'h00) begin failures++; $display("FAIL reset_digits got=%h required=00", digits); end
        for (int k = 0; k < 20; k++) begin
            exp = row_drive((k / int'(SCAN_CYCLES)) % 4);
            checks++;
            if (rows !== exp) begin
                failures++;
                $display("FAIL scan_sequence cycle=%0d got=%b required=%b", k, rows, exp);
            end
            tick(1);
        end
    endtask

    task automatic test_press_release();
        press_and_release(1, 1, 10);
        checks++;
        if (digits !== 8'h05) begin failures++; $display("FAIL digits_after_5 got=%h required=05", digits); end
        press_and_release(2, 2, 10);
        checks++;
        if (digits !== 8'h59) begin failures++; $display("FAIL digits_after_9 got=%h required=59", digits); end
    endtask

    task automatic test_bounce(input int r, input int c);
        logic [3:0] seen;
        seen = '0;
        clear_events();
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) pressed[r*4+c] = ~pressed[r*4+c];
            for (int k = 0; k < 4; k++)
                if (rows[k] == 1'b0) seen[k] = 1'b1;
            tick(1);
        end
        pressed = '0;
        tick(20);
        checks++;
        if (ev_code.size() != 0) begin
            failures++;
            $display("FAIL bounce_event key=%h got=%0d events required=0", key_of(r, c), ev_code.size());
        end
        checks++;
        if ($countones(seen) < 2) begin
            failures++;
            $display("FAIL bounce_scan rows_seen=%b required at least two rows", seen);
        end
    endtask

    task automatic test_same_row(input int r, input int c1, input int c2);
        clear_events();
        pressed[r*4+c1] = 1'b1;
        pressed[r*4+c2] = 1'b1;
        tick(60);
        pressed = '0;
        tick(10);
        checks++;
        if (ev_code.size() != 0) begin
            failures++;
            $display("FAIL same_row_event row=%0d cols=%0d,%0d got=%0d events required=0",
                     r, c1, c2, ev_code.size());
        end
    endtask

    task automatic test_ghost_hold();
        bit got;
        int gap;
        clear_events();
        pressed[0*4+3] = 1'b1;
        wait_event(80, got);
        checks++;
        if (!got) begin failures++; $display("FAIL ghost_press_timeout got no event required key A"); end
        tick(5);
        pressed[3*4+1] = 1'b1;
        tick(10);
        pressed = '0;
        tick(25);
        model_digits = {model_digits[3:0], 4'hA};
        checks++;
        if (ev_code.size() != 1) begin failures++; $display("FAIL ghost_count got=%0d required=1", ev_code.size()); end
        if (ev_code.size() > 0) begin
            checks++;
            if (ev_code[0] !== 4'hA) begin failures++; $display("FAIL ghost_code got=%h required=A", ev_code[0]); end
        end
        checks++;
        if (digits !== model_digits) begin failures++; $display("FAIL ghost_digits got=%h required=%h", digits, model_digits); end

        clear_events();
        gap = int'($urandom_range(6, 1));
        pressed[0*4+3] = 1'b1;
        wait_event(80, got);
        tick(5);
        pressed = '0;
        tick(gap);
        pressed[0*4+3] = 1'b1;
        tick(10);
        pressed = '0;
        tick(25);
        model_digits = {model_digits[3:0], 4'hA};
        checks++;
        if (ev_code.size() != 1) begin
            failures++;
            $display("FAIL short_release_count gap=%0d got=%0d required=1", gap, ev_code.size());
        end
        checks++;
        if (digits !== model_digits) begin failures++; $display("FAIL short_release_digits got=%h required=%h", digits, model_digits); end
    endtask

    task automatic test_random_keys();
        for (int i = 0; i < 8; i++)
            press_and_release(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(15, 2)));
    endtask

    task automatic test_long_hold();
        bit got;
        int exp_n;
`ifdef KEYPAD_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        clear_events();
        pressed[2*4+3] = 1'b1;
        wait_event(80, got);
        tick(100);
        pressed = '0;
        tick(25);
        checks++;
        if (ev_code.size() != exp_n) begin
            failures++;
            $display("FAIL long_hold_count got=%0d required=%0d", ev_code.size(), exp_n);
        end
        for (int i = 0; i < ev_code.size(); i++) begin
            checks++;
            if (ev_code[i] !== 4'hC) begin failures++; $display("FAIL long_hold_code idx=%0d got=%h required=C", i, ev_code[i]); end
        end
        for (int i = 1; i < ev_cyc.size(); i++) begin
            checks++;
            if (ev_cyc[i] - ev_cyc[i-1] != int'(REPEAT_CYCLES)) begin
                failures++;
                $display("FAIL repeat_spacing idx=%0d got=%0d required=%0d", i, ev_cyc[i] - ev_cyc[i-1], REPEAT_CYCLES);
            end
        end
        for (int i = 0; i < exp_n; i++) model_digits = {model_digits[3:0], 4'hC};
        checks++;
        if (digits !== model_digits) begin failures++; $display("FAIL long_hold_digits got=%h required=%h", digits, model_digits); end
`ifdef KEYPAD_REPEAT_EN
        checks++;
        if (digits !== 8'hCC) begin failures++; $display("FAIL repeat_digits got=%h required=CC", digits); end
`endif
    endtask

    task automatic test_reset_in_held();
        bit got;
        int r;
        int c;
        r = int'($urandom_range(3, 0));
        c = int'($urandom_range(3, 0));
        clear_events();
        pressed[r*4+c] = 1'b1;
        wait_event(80, got);
        checks++;
        if (!got) begin failures++; $display("FAIL held_press_timeout key=%h got no event", key_of(r, c)); end
        tick(3);
        reset   = 1'b1;
        pressed = '0;
        tick(1);
        checks++;
        if (rows !== 4'b1110) begin failures++; $display("FAIL held_reset_rows got=%b required=1110", rows); end
        checks++;
        if (key_valid !== 1'b0) begin failures++; $display("FAIL held_reset_kv got=%b required=0", key_valid); end
        checks++;
        if (key_code !== 4'h0) begin failures++; $display("FAIL held_reset_code got=%h required=0", key_code); end
        checks++;
        if (digits !== 8'h00) begin failures++; $display("FAIL held_reset_digits got=%h required=00", digits); end
        reset = 1'b0;
        model_digits = '0;
        clear_events();
        tick(30);
        checks++;
        if (ev_code.size() != 0) begin failures++; $display("FAIL post_reset_events got=%0d required=0", ev_code.size()); end
        checks++;
        if (digits !== model_digits) begin failures++; $display("FAIL post_reset_digits got=%h required=%h", digits, model_digits); end
    endtask

    initial begin
        int c1;
        test_reset();
        test_press_release();
        test_bounce(2, 0);
        test_bounce(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        test_same_row(1, 0, 2);
        c1 = int'($urandom_range(3, 0));
        test_same_row(int'($urandom_range(3, 0)), c1, (c1 + int'($urandom_range(3, 1))) % 4);
        test_ghost_hold();
        test_random_keys();
        test_long_hold();
        test_reset_in_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
